// File: rtl/mem_rq_pkg.sv
// mem_rq_pkg: request/response structs and field positions for the 65-bit request / 32-bit response memory interface
package mem_rq_pkg;
  localparam int ADDR_LSB = 33;
  localparam int ISWRITE_BIT = 32;
  localparam int RQ_W = ADDR_LSB + 32;
  localparam int RS_W = ISWRITE_BIT + 1;
  typedef struct packed {
    logic [31:0] addr;
    logic        iswrite;
    logic [31:0] data;
  } mem_rq_t;
  typedef struct packed {
    logic [31:0] data;
    logic        iswrite;
  } mem_rs_t;
endpackage

// File: rtl/mem_rq_fifo.sv
// mem_rq_fifo: generic W-bit x D-entry FIFO; head driven from registers and zeroed when empty.
// Ports: clock, reset (async, active-high), push/din, pop, dout (head), empty, full.
// The caller guarantees no push while full and no pop while empty.
module mem_rq_fifo #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = D > 1 ? $clog2(D) : 1;
  logic [W-1:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(D);
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clock)
    if (push) mem[wp] <= din;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/mem_rq_initiator.sv
// mem_rq_initiator: processor-side initiator issuing core load/store requests to a memory responder and returning in-order responses.
// Ports: clock, reset (async, active-high);
//   core_rq_*  : core request valid/ready with addr, iswrite, data;
//   core_rs_*  : core response valid/ready with data (0 for stores) and iswrite;
//   obtain_rq_get / RDY_ / EN_ : responder takes the head request {addr, iswrite, data};
//   send_rs_put / RDY_ / EN_   : responder delivers one response per request, in order.
// Optional macro MEM_RQ_INITIATOR_PROTO_CHECK_EN adds sticky output proto_err for ignored ENs.
module mem_rq_initiator
  import mem_rq_pkg::*;
#(
  parameter int RQ_DEPTH = 2,
  parameter int CREDITS = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            core_rq_valid,
  output logic            core_rq_ready,
  input  logic [31:0]     core_rq_addr,
  input  logic            core_rq_iswrite,
  input  logic [31:0]     core_rq_data,
  output logic            core_rs_valid,
  input  logic            core_rs_ready,
  output logic [31:0]     core_rs_data,
  output logic            core_rs_iswrite,
  input  logic            EN_obtain_rq_get,
  output logic [RQ_W-1:0] obtain_rq_get,
  output logic            RDY_obtain_rq_get,
  input  logic [31:0]     send_rs_put,
  input  logic            EN_send_rs_put,
  output logic            RDY_send_rs_put
`ifdef MEM_RQ_INITIATOR_PROTO_CHECK_EN
  ,
  output logic            proto_err
`endif
);
  localparam int CW = $clog2(CREDITS + 1);
  logic alive;
  logic [CW-1:0] inflight, credit_used;
  mem_rq_t rq_in, rq_head;
  mem_rs_t rs_in, rs_head;
  logic rq_empty, rq_full, tag_empty, tag_full, tag_head, rs_empty, rs_full;
  logic push_rq, issue, accept, bypass, rs_tag, pop_rs;
  // alive holds ready low through reset and raises it on the first clock after release
  assign core_rq_ready = alive && !rq_full;
  assign push_rq = core_rq_valid && core_rq_ready;
  assign rq_in = '{addr: core_rq_addr, iswrite: core_rq_iswrite, data: core_rq_data};
  assign RDY_obtain_rq_get = !rq_empty && credit_used < CW'(CREDITS);
  assign obtain_rq_get = rq_head;
  assign issue = EN_obtain_rq_get && RDY_obtain_rq_get;
  assign RDY_send_rs_put = inflight != '0 || RDY_obtain_rq_get;
  // with nothing in flight a response can only belong to the request issued this very cycle
  assign accept = EN_send_rs_put && (inflight != '0 || issue);
  assign bypass = accept && inflight == '0;
  assign rs_tag = bypass ? rq_head.iswrite : tag_head;
  assign rs_in = '{data: rs_tag ? 32'h0 : send_rs_put, iswrite: rs_tag};
  assign core_rs_valid = !rs_empty;
  assign core_rs_data = rs_head.data;
  assign core_rs_iswrite = rs_head.iswrite;
  assign pop_rs = core_rs_valid && core_rs_ready;
  mem_rq_fifo #(.W(RQ_W), .D(RQ_DEPTH)) u_rq (
    .clock(clock), .reset(reset), .push(push_rq), .din(rq_in),
    .pop(issue), .dout(rq_head), .empty(rq_empty), .full(rq_full)
  );
  mem_rq_fifo #(.W(1), .D(CREDITS)) u_tag (
    .clock(clock), .reset(reset), .push(issue && !bypass && !tag_full), .din(rq_head.iswrite),
    .pop(accept && !bypass && !tag_empty), .dout(tag_head), .empty(tag_empty), .full(tag_full)
  );
  mem_rq_fifo #(.W(RS_W), .D(CREDITS)) u_rs (
    .clock(clock), .reset(reset), .push(accept && !rs_full), .din(rs_in),
    .pop(pop_rs), .dout(rs_head), .empty(rs_empty), .full(rs_full)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      alive <= 1'b0;
      inflight <= '0;
      credit_used <= '0;
    end else begin
      alive <= 1'b1;
      inflight <= inflight + CW'(issue) - CW'(accept);
      credit_used <= credit_used + CW'(issue) - CW'(pop_rs);
    end
`ifdef MEM_RQ_INITIATOR_PROTO_CHECK_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) proto_err <= 1'b0;
    else if ((EN_send_rs_put && !RDY_send_rs_put) || (EN_obtain_rq_get && !RDY_obtain_rq_get)) proto_err <= 1'b1;
`endif
endmodule

// File: tb/tb_mem_rq_initiator.sv
// tb_mem_rq_initiator: directed and random stimulus checked against a queue-based model of the initiator
module tb_mem_rq_initiator;
  import mem_rq_pkg::*;
  localparam int RQ_DEPTH = 2;
  localparam int CREDITS = 4;
  logic clk = 1'b0;
  logic reset;
  logic core_rq_valid, core_rq_ready, core_rq_iswrite;
  logic [31:0] core_rq_addr, core_rq_data;
  logic core_rs_valid, core_rs_ready, core_rs_iswrite;
  logic [31:0] core_rs_data;
  logic EN_obtain_rq_get, RDY_obtain_rq_get;
  logic [64:0] obtain_rq_get;
  logic [31:0] send_rs_put;
  logic EN_send_rs_put, RDY_send_rs_put;
`ifdef MEM_RQ_INITIATOR_PROTO_CHECK_EN
  logic proto_err;
`endif
  int total = 0;
  int bad = 0;
  logic [64:0] req_q[$];
  bit iss_q[$];
  logic [32:0] rs_q[$];

  always #5 clk = ~clk;

  mem_rq_initiator #(.RQ_DEPTH(RQ_DEPTH), .CREDITS(CREDITS)) dut (
    .clock(clk), .reset(reset),
    .core_rq_valid(core_rq_valid), .core_rq_ready(core_rq_ready),
    .core_rq_addr(core_rq_addr), .core_rq_iswrite(core_rq_iswrite), .core_rq_data(core_rq_data),
    .core_rs_valid(core_rs_valid), .core_rs_ready(core_rs_ready),
    .core_rs_data(core_rs_data), .core_rs_iswrite(core_rs_iswrite),
    .EN_obtain_rq_get(EN_obtain_rq_get), .obtain_rq_get(obtain_rq_get), .RDY_obtain_rq_get(RDY_obtain_rq_get),
    .send_rs_put(send_rs_put), .EN_send_rs_put(EN_send_rs_put), .RDY_send_rs_put(RDY_send_rs_put)
`ifdef MEM_RQ_INITIATOR_PROTO_CHECK_EN
    , .proto_err(proto_err)
`endif
  );

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: compare DUT against the model at the falling edge, then drive inputs and
  // advance the model by the transfers that the coming rising edge will perform.
  task automatic cyc(input bit push, input logic [31:0] a, input bit w, input logic [31:0] d,
                     input bit get, input bit put, input logic [31:0] pd, input bit rr);
    bit erdy, g, p, wb;
    int rqsz;
    logic [64:0] h;
    @(negedge clk);
    rqsz = req_q.size();
    erdy = rqsz > 0 && (iss_q.size() + rs_q.size()) < CREDITS;
    chk("rq_ready", 65'(core_rq_ready), 65'(rqsz < RQ_DEPTH));
    chk("rdy_get", 65'(RDY_obtain_rq_get), 65'(erdy));
    if (erdy) chk("get_head", obtain_rq_get, req_q[0]);
    chk("rdy_put", 65'(RDY_send_rs_put), 65'(iss_q.size() > 0 || erdy));
    chk("rs_valid", 65'(core_rs_valid), 65'(rs_q.size() > 0));
    if (rs_q.size() > 0) chk("rs_head", 65'({core_rs_data, core_rs_iswrite}), 65'(rs_q[0]));
    g = get && erdy;
    p = put && (iss_q.size() > 0 || g);
    core_rq_valid = push;
    core_rq_addr = a;
    core_rq_iswrite = w;
    core_rq_data = d;
    EN_obtain_rq_get = g;
    EN_send_rs_put = p;
    send_rs_put = pd;
    core_rs_ready = rr;
    if (rr && rs_q.size() > 0) void'(rs_q.pop_front());
    if (g) begin
      h = req_q.pop_front();
      iss_q.push_back(h[ISWRITE_BIT]);
    end
    if (p) begin
      wb = iss_q.pop_front();
      rs_q.push_back({wb ? 32'h0 : pd, wb});
    end
    if (push && rqsz < RQ_DEPTH) req_q.push_back({a, w, d});
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (req_q.size() + iss_q.size() + rs_q.size()) > 0; i++)
      cyc(0, 0, 0, 0, 1, 1, $urandom, 1);
    chk("drain_left", 65'(req_q.size() + iss_q.size() + rs_q.size()), 65'(0));
    idle();
  endtask

  initial begin
    reset = 1'b1;
    core_rq_valid = 0; core_rq_addr = 0; core_rq_iswrite = 0; core_rq_data = 0;
    core_rs_ready = 0; EN_obtain_rq_get = 0; send_rs_put = 0; EN_send_rs_put = 0;
    repeat (2) @(negedge clk);
    chk("rst_rq_ready", 65'(core_rq_ready), 65'(0));
    chk("rst_rs_valid", 65'(core_rs_valid), 65'(0));
    chk("rst_rdy_get", 65'(RDY_obtain_rq_get), 65'(0));
    chk("rst_rdy_put", 65'(RDY_send_rs_put), 65'(0));
    chk("rst_get_data", obtain_rq_get, 65'(0));
    reset = 1'b0;
    @(posedge clk);

    cyc(1, 32'h100, 0, 32'h0, 0, 0, 0, 0);
    cyc(1, 32'h104, 1, 32'hDEADBEEF, 1, 1, 32'h12345678, 0);
    cyc(0, 0, 0, 0, 1, 1, 32'hCAFEF00D, 1);
    chk("zl_load", 65'({core_rs_data, core_rs_iswrite}), 65'({32'h12345678, 1'b0}));
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("zl_store", 65'({core_rs_data, core_rs_iswrite}), 65'({32'h0, 1'b1}));
    idle();

    cyc(1, 32'h10, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i < 5; i++) cyc(1, 32'h10 + 32'(4 * i), 0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 0, 1);
    chk("credit_stall", 65'(RDY_obtain_rq_get), 65'(0));
    repeat (9) cyc(0, 0, 0, 0, 1, 0, 0, 1);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 0, 0, 0, i <= 4, 32'(i), 1);
      if (i > 1) chk("delayed_data", 65'(core_rs_data), 65'(i - 1));
    end
    drain();

    cyc(1, 32'h300, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 5; i++) cyc(1, 32'h300 + 32'(4 * i), 0, 0, 1, 1, 32'(100 + i), 0);
    cyc(0, 0, 0, 0, 1, 1, 32'h99, 0);
    chk("bp_stall", 65'(RDY_obtain_rq_get), 65'(0));
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("bp_resume", 65'(RDY_obtain_rq_get), 65'(1));
    drain();

    cyc(1, 32'h400, 1, 32'h1, 0, 0, 0, 0);
    cyc(1, 32'h404, 1, 32'h2, 0, 0, 0, 0);
    cyc(1, 32'h408, 1, 32'h3, 0, 0, 0, 0);
    chk("rq_full", 65'(core_rq_ready), 65'(0));
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    idle();
    chk("rq_refill", 65'(core_rq_ready), 65'(1));
    drain();

    cyc(1, 32'h500, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h504, 1, 32'h7, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    idle();
    #2 reset = 1'b1;
    #1;
    chk("mid_rq_ready", 65'(core_rq_ready), 65'(0));
    chk("mid_rs_valid", 65'(core_rs_valid), 65'(0));
    chk("mid_rdy_get", 65'(RDY_obtain_rq_get), 65'(0));
    chk("mid_rdy_put", 65'(RDY_send_rs_put), 65'(0));
    chk("mid_get_data", obtain_rq_get, 65'(0));
    req_q.delete();
    iss_q.delete();
    rs_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    cyc(1, 32'h200, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 32'h55AA, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("post_rst_load", 65'({core_rs_data, core_rs_iswrite}), 65'({32'h55AA, 1'b0}));
    idle();

    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 1) == 1, $urandom & ~32'h3, $urandom_range(0, 1) == 1, $urandom,
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 3) != 0);
    drain();

`ifdef MEM_RQ_INITIATOR_PROTO_CHECK_EN
    chk("proto_clear", 65'(proto_err), 65'(0));
    EN_send_rs_put = 1'b1;
    send_rs_put = 32'hBAD;
    @(negedge clk);
    EN_send_rs_put = 1'b0;
    chk("proto_set", 65'(proto_err), 65'(1));
    chk("proto_no_rs", 65'(core_rs_valid), 65'(0));
    repeat (2) @(negedge clk);
    chk("proto_sticky", 65'(proto_err), 65'(1));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_rq_initiator.md
Name: mem_rq_initiator

Overview:
- Processor-side initiator for the 65-bit memory request / 32-bit response interface.
- Accepts load/store commands from core logic over valid/ready.
- Presents them to an external memory responder as a Get method (`obtain_rq_get`) and accepts that responder's replies as a Put method (`send_rs_put`).
- Tracks outstanding requests in order and returns load data or store acks to the core.

Parameters:
- RQ_DEPTH, 2: core request queue entries (power of 2, ≥2).
- CREDITS, 4: max requests issued to memory plus responses buffered toward the core (power of 2, ≥1).

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- core_rq_valid  in  1  core request valid.
- core_rq_ready  out  1  queue has space.
- core_rq_addr  in  32  byte address.
- core_rq_iswrite  in  1  1 = store, 0 = load.
- core_rq_data  in  32  store data (don't-care for loads).
- core_rs_valid  out  1  response available.
- core_rs_ready  in  1  core consumes response.
- core_rs_data  out  32  load data; 0 for store acks.
- core_rs_iswrite  out  1  response belongs to a store.
- EN_obtain_rq_get  in  1  responder takes head request this cycle.
- obtain_rq_get  out  65  {addr[64:33], iswrite[32], data[31:0]}.
- RDY_obtain_rq_get  out  1  head request presentable.
- send_rs_put  in  32  response data.
- EN_send_rs_put  in  1  responder delivers a response this cycle.
- RDY_send_rs_put  out  1  a response can be accepted.

Behaviour:
- Reset: asynchronous.
  - All queues empty, `inflight` = 0, `credit_used` = 0.
  - Outputs: `core_rq_ready`=0 while reset is asserted, 1 on the first cycle after; `core_rs_valid`=0, `RDY_obtain_rq_get`=0, `RDY_send_rs_put`=0, `obtain_rq_get`=0.
  - Reset mid-operation discards everything in flight. Late responses after reset are covered by the protocol rule below.
- Request queue: FIFO of RQ_DEPTH entries.
  - `core_rq_ready` = !full. Push when valid&&ready.
  - Simultaneous push and pop when full is not allowed, because ready is already low.
- Issue: `RDY_obtain_rq_get` = rq_queue non-empty && `credit_used` < CREDITS. `obtain_rq_get` = queue head, driven from registers (no combinational path from core inputs).
  - On EN_obtain_rq_get (only legal while RDY is high): pop the head, push its iswrite bit into the tag FIFO (depth CREDITS), `inflight`++, `credit_used`++.
- Response acceptance: `RDY_send_rs_put` = (`inflight` != 0) || `RDY_obtain_rq_get`.
  - A response arriving in the same cycle as EN_obtain_rq_get, with `inflight` == 0, belongs to that same request. This is the zero-latency responder case; the tag bypasses the tag FIFO.
  - Otherwise the response pops the oldest tag.
  - Responses are strictly in order: exactly one per request, writes included.
  - The response is pushed into the response FIFO (depth CREDITS) as {data or 0 if write, iswrite}.
- Response FIFO cannot overflow: `credit_used` bounds inflight + buffered responses.
  - `core_rs_valid` = response FIFO non-empty; data and iswrite come from the head, registered.
  - On core_rs_valid&&core_rs_ready: pop and `credit_used`--.
- Simultaneous events in one cycle: issue, response and core pop all update `inflight`/`credit_used` by net delta.
- Protocol rules:
  - EN_send_rs_put with `RDY_send_rs_put` low is ignored (no state change).
  - EN_obtain_rq_get with RDY low is ignored.
- Latency: core push → `RDY_obtain_rq_get` next cycle. Response put → `core_rs_valid` next cycle.

Optional Feature:
- Macro: MEM_RQ_INITIATOR_PROTO_CHECK_EN.
- When defined, adds output `proto_err` (1 bit, reset 0).
  - It sets sticky on any ignored EN (EN_send_rs_put without RDY, or EN_obtain_rq_get without RDY).
  - It clears only on reset.
- When undefined, the port and checking logic are absent and behaviour is otherwise identical.

Decomposition:
- Package mem_rq_pkg holds:
  - the request struct {addr 32, iswrite 1, data 32} and its 65-bit pack order;
  - field bit positions (ADDR_LSB=33, ISWRITE_BIT=32);
  - the response struct {data 32, iswrite 1}.
- One generic sub-module, mem_rq_fifo (parameterised width/depth, registered outputs). It is instantiated three times: request, tag, response.

Test Plan:
- Zero-latency responder (EN_get and EN_put in the same cycle as RDY): load 0x100 then store 0x104←0xDEADBEEF, response 0x12345678 to the load → core sees {0x12345678, iswrite=0} then {0, iswrite=1}, in order.
- Delayed responder: issue 4 loads, hold EN_send_rs_put off for 10 cycles → RDY_obtain_rq_get drops after the 4th issue (credit_used=4); then puts 1,2,3,4 → core receives 1,2,3,4.
- Core backpressure: core_rs_ready=0, 4 loads answered → 5th request is not issued until the core pops one; no response is lost.
- Request queue full: 2 pushes with EN_get=0 → core_rq_ready=0; one EN_get → ready=1 the next cycle.
- Reset asserted with 2 requests in flight → all outputs return to reset values asynchronously; after release, a new load to 0x200 completes normally.
- With the macro defined: EN_send_rs_put while inflight=0 and no request pending → proto_err=1, core_rs_valid stays 0.
